// File: rtl/aes_ht_pkg.sv
// Shared AES-128 types and GF(2^8) helpers for the iterative sequencer.
// S-box is computed as GF inverse plus affine map, so no 256-entry table is kept.
package aes_ht_pkg;

  typedef logic [255:0] aes_state_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_HOLD  = 2'd2
  } aes_fsm_t;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse is b^254: six square-and-multiply steps reach b^127, one more square gives b^254.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] inv;
    r = b;
    for (int i = 0; i < 6; i++) r = gf_mul(gf_mul(r, r), b);
    inv = gf_mul(r, r);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Byte 0 (row 0) sits in bits [7:0].
  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = c[7:0];
    a1 = c[15:8];
    a2 = c[23:16];
    a3 = c[31:24];
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {b3, b2, b1, b0};
  endfunction

endpackage

// File: rtl/aes_ht_round.sv
// One combinational AES-128 round: key schedule step plus data round, MixColumns skipped when last.
// State is {key, data}; AES byte i lives in bits [8i+7:8i] of each half.
module aes_ht_round
  import aes_ht_pkg::*;
(
  input  aes_state_t  s_in,
  input  logic [3:0]  rnd,
  input  logic        last,
  output aes_state_t  s_out
);

  logic [127:0] w_key;
  logic [127:0] w_data;
  logic [7:0]   w_rcon;
  logic [31:0]  w_rot;
  logic [31:0]  w_t;
  logic [127:0] w_nkey;
  logic [127:0] w_sb;
  logic [127:0] w_sr;
  logic [127:0] w_mc;

  assign w_key  = s_in[255:128];
  assign w_data = s_in[127:0];
  assign w_rcon = (rnd >= 4'd1 && rnd <= 4'd10) ? RCON[rnd] : 8'h00;

  always_comb begin
    w_rot  = {w_key[103:96], w_key[127:104]};
    w_t    = {sbox(w_rot[31:24]), sbox(w_rot[23:16]), sbox(w_rot[15:8]), sbox(w_rot[7:0]) ^ w_rcon};
    w_nkey = '0;
    w_sb   = '0;
    w_sr   = '0;
    w_mc   = '0;
    w_nkey[31:0]   = w_key[31:0]   ^ w_t;
    w_nkey[63:32]  = w_key[63:32]  ^ w_nkey[31:0];
    w_nkey[95:64]  = w_key[95:64]  ^ w_nkey[63:32];
    w_nkey[127:96] = w_key[127:96] ^ w_nkey[95:64];
    for (int i = 0; i < 16; i++) w_sb[8*i +: 8] = sbox(w_data[8*i +: 8]);
    // Row r rotates left by r columns.
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        w_sr[8*(4*c+r) +: 8] = w_sb[8*(4*((c+r)%4)+r) +: 8];
    for (int c = 0; c < 4; c++) w_mc[32*c +: 32] = mix_col(w_sr[32*c +: 32]);
    s_out = {w_nkey, (last ? w_sr : w_mc) ^ w_nkey};
  end

endmodule

// File: rtl/aes_ht_seq.sv
// Iterative AES-128 encryptor: RPC chained round cores per clock, result after 10/RPC edges.
// Single job in flight; result held in HOLD until out_ready, in_ready low until then.
module aes_ht_seq
  import aes_ht_pkg::*;
#(
  parameter int RPC = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] g_input,
  input  logic [127:0] e_input,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] o,
  output logic         busy,
  output logic [3:0]   round
);

  if (!(RPC == 1 || RPC == 2 || RPC == 5)) begin : g_bad_rpc
    $error("aes_ht_seq: RPC must be 1, 2 or 5");
  end

  aes_fsm_t     r_state, w_state_nxt;
  aes_state_t   r_s, w_s_nxt;
  logic [3:0]   r_round, w_round_nxt;
  logic [127:0] r_o, w_o_nxt;
  logic         w_done;
  aes_state_t   w_chain [0:RPC];

  assign w_chain[0] = r_s;

  for (genvar k = 0; k < RPC; k++) begin : g_core
    logic [3:0] w_rnd;
    assign w_rnd = r_round + 4'(k);
    aes_ht_round u_round (
      .s_in  (w_chain[k]),
      .rnd   (w_rnd),
      .last  (w_rnd == 4'd10),
      .s_out (w_chain[k+1])
    );
  end

  // Last round applied this cycle is round+RPC-1; round never exceeds 11 so no wrap.
  assign w_done = (r_round + 4'(RPC - 1)) >= 4'd10;

  always_comb begin
    w_state_nxt = r_state;
    w_s_nxt     = r_s;
    w_round_nxt = r_round;
    w_o_nxt     = r_o;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_s_nxt     = {g_input, e_input ^ g_input};
          w_round_nxt = 4'd1;
          w_state_nxt = ST_ROUND;
        end
      end
      ST_ROUND: begin
        w_s_nxt     = w_chain[RPC];
        w_round_nxt = r_round + 4'(RPC);
        if (w_done) begin
          w_o_nxt     = w_chain[RPC][127:0];
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_s     <= '0;
      r_round <= '0;
      r_o     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_s     <= w_s_nxt;
      r_round <= w_round_nxt;
      r_o     <= w_o_nxt;
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_HOLD);
  assign busy      = (r_state != ST_IDLE);
  assign o         = r_o;
  assign round     = r_round;

endmodule
